mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mc_common_pkg.sv | 38 +++
 rtl/llsc_resv_unit.sv | 42 ++++
 rtl/mem_port_arb.sv | 116 +++++++++++
 tb/tb_mem_port_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_common_pkg.sv
// Shared memory-controller types: request/response buses, arbiter state,
// LL/SC reservation record and requester tag.
package mc_common_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic              atomic;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] rdata;
   } mem_resp_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      FAILRSP
   } arb_state_e;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
   } resv_t;

   typedef enum logic {
      SRC_IF,
      SRC_D
   } src_e;

endpackage

// File: rtl/llsc_resv_unit.sv
// Single LL/SC reservation: set by LL, cleared by any SC or by a plain write
// to the reserved word; reports whether an SC presented now would succeed.
module llsc_resv_unit
   import mc_common_pkg::*;
#(
   parameter int RESV_LSB = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_grant,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_wr,
   input  logic              i_atomic,
   output logic              o_sc_pass
);

   localparam logic [ADDR_W-1:0] RESV_MASK =
      ~((ADDR_W'(1) << RESV_LSB) - ADDR_W'(1));

   resv_t             r_resv;
   logic [ADDR_W-1:0] w_addr_m;
   logic              w_match;

   assign w_addr_m  = i_addr & RESV_MASK;
   assign w_match   = r_resv.valid && (r_resv.addr == w_addr_m);
   assign o_sc_pass = w_match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resv <= '0;
      end else if (i_grant) begin
         if (i_atomic && !i_wr) begin
            r_resv.valid <= 1'b1;
            r_resv.addr  <= w_addr_m;
         end else if (i_atomic || (i_wr && w_match)) begin
            // any SC, pass or fail, consumes the reservation
            r_resv.valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mem_port_arb.sv
// Two-requester arbiter (ifetch / data) onto one memory port, one transaction
// in flight, data priority with ifetch anti-starvation, LL/SC on the data side.
module mem_port_arb
   import mc_common_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int RESV_LSB   = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  mem_req_t  if_req,
   output mem_resp_t if_resp,
   input  mem_req_t  d_req,
   output mem_resp_t d_resp,
   output mem_req_t  m_req,
   input  logic      m_ready,
   input  mem_resp_t m_resp
);

   localparam int             CW         = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0]  STARVE_TOP = CW'(STARVE_MAX);

   arb_state_e    r_state;
   src_e          r_src;
   mem_req_t      r_req;
   logic          r_is_sc;
   logic [CW-1:0] r_starve_cnt;

   logic     w_if_wins;
   logic     w_d_grant;
   logic     w_is_sc;
   logic     w_sc_pass;
   mem_req_t w_d_fwd;

   assign w_if_wins = if_req.valid && (!d_req.valid || (r_starve_cnt == STARVE_TOP));
   assign w_d_grant = (r_state == IDLE) && d_req.valid && !w_if_wins;
   assign w_is_sc   = d_req.atomic && d_req.wr;

   // LL goes out as a plain read, a passing SC as a plain write
   always_comb begin
      w_d_fwd        = d_req;
      w_d_fwd.atomic = 1'b0;
   end

   llsc_resv_unit #(
      .RESV_LSB (RESV_LSB)
   ) u_resv (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_grant   (w_d_grant),
      .i_addr    (d_req.addr),
      .i_wr      (d_req.wr),
      .i_atomic  (d_req.atomic),
      .o_sc_pass (w_sc_pass)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_src        <= SRC_IF;
         r_req        <= '0;
         r_is_sc      <= 1'b0;
         r_starve_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_d_grant) begin
                  r_src   <= SRC_D;
                  r_req   <= w_d_fwd;
                  r_is_sc <= w_is_sc;
                  if (if_req.valid && (r_starve_cnt != STARVE_TOP))
                     r_starve_cnt <= r_starve_cnt + CW'(1);
                  r_state <= (w_is_sc && !w_sc_pass) ? FAILRSP : ISSUE;
               end else if (w_if_wins) begin
                  r_src        <= SRC_IF;
                  r_req        <= if_req;
                  r_is_sc      <= 1'b0;
                  r_starve_cnt <= '0;
                  r_state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_ready) r_state <= WAIT;
            end
            WAIT: begin
               if (m_resp.valid) r_state <= IDLE;
            end
            FAILRSP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign m_req = (r_state == ISSUE) ? r_req : '0;

   always_comb begin
      if_resp = '0;
      d_resp  = '0;
      if ((r_state == WAIT) && m_resp.valid) begin
         if (r_src == SRC_IF) begin
            if_resp = m_resp;
         end else begin
            d_resp = m_resp;
            if (r_is_sc) d_resp.rdata = '0;
         end
      end else if (r_state == FAILRSP) begin
         d_resp.valid = 1'b1;
         d_resp.rdata = DATA_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: arbitration timing, anti-starvation,
// LL/SC outcomes, memory back-pressure and reset mid-transaction.
module tb_mem_port_arb;
   import mc_common_pkg::*;

   logic      clk = 1'b0;
   logic      rst_n;
   mem_req_t  if_req;
   mem_req_t  d_req;
   mem_req_t  m_req;
   mem_resp_t if_resp;
   mem_resp_t d_resp;
   mem_resp_t m_resp;
   logic      m_ready;

   int        n_tests = 0;
   int        n_fail  = 0;
   int        n_acc   = 0;
   int        acc0;
   int        lat;
   int        n_seen;
   bit        mem_auto = 1'b1;
   mem_req_t  last_acc = '0;
   logic [31:0] rd;
   logic [31:0] gaddr [5];

   mem_port_arb #(
      .STARVE_MAX (4),
      .RESV_LSB   (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .if_req  (if_req),
      .if_resp (if_resp),
      .d_req   (d_req),
      .d_resp  (d_resp),
      .m_req   (m_req),
      .m_ready (m_ready),
      .m_resp  (m_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic mem_req_t mk(input logic wr, input logic at,
                                   input logic [31:0] addr, input logic [31:0] wdata);
      mem_req_t r;
      r.valid  = 1'b1;
      r.wr     = wr;
      r.atomic = at;
      r.addr   = addr;
      r.wdata  = wdata;
      return r;
   endfunction

   // One clock: per-cycle response-port invariants, then a 1-cycle-latency memory.
   task automatic clk_step();
      logic acc;
      @(negedge clk);
      check("resp_exclusive", 96'({if_resp.valid, d_resp.valid} == 2'b11), 96'(0));
      check("if_resp_zero_when_idle", 96'(if_resp.valid ? '0 : if_resp), 96'(0));
      check("d_resp_zero_when_idle", 96'(d_resp.valid ? '0 : d_resp), 96'(0));
      acc = m_req.valid && m_ready;
      if (acc) begin
         n_acc++;
         last_acc = m_req;
      end
      @(posedge clk);
      #1;
      m_resp = '0;
      if (acc && mem_auto) begin
         m_resp.valid = 1'b1;
         m_resp.rdata = 32'h5000_0000 | last_acc.addr;
      end
   endtask

   // Idle gap, present a data request, wait (bounded) for its response.
   task automatic run_d(input mem_req_t r, output logic [31:0] rdata, output int l);
      clk_step();
      #2;
      d_req = r;
      l     = 0;
      rdata = '0;
      for (int c = 1; c <= 12; c++) begin
         clk_step();
         #2;
         if (d_resp.valid) begin
            rdata = d_resp.rdata;
            l     = c;
            break;
         end
      end
      check("d_resp_timeout", 96'(l != 0), 96'(1));
      d_req = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed still running, expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n   = 1'b0;
      m_ready = 1'b1;
      if_req  = '0;
      d_req   = '0;
      m_resp  = '0;
      for (int i = 0; i < 5; i++) gaddr[i] = '0;
      repeat (2) @(posedge clk);
      #3;
      check("rst_m_req", 96'(m_req), 96'(0));
      check("rst_if_resp", 96'(if_resp), 96'(0));
      check("rst_d_resp", 96'(d_resp), 96'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clk_step();
      #2;
      check("idle_no_m_req", 96'(m_req), 96'(0));

      // both valid in cycle 0: data response cycle 2, ifetch response cycle 5
      d_req  = mk(1'b0, 1'b0, 32'h0000_0010, 32'h0);
      if_req = mk(1'b0, 1'b0, 32'h0000_0020, 32'h0);
      check("c0_m_req_idle", 96'(m_req.valid), 96'(0));
      clk_step(); #2;
      check("c1_m_req_data", 96'(m_req), 96'(mk(1'b0, 1'b0, 32'h10, 32'h0)));
      clk_step(); #2;
      check("c2_d_resp", 96'(d_resp), 96'({1'b1, 32'h5000_0010}));
      check("c2_if_resp_off", 96'(if_resp.valid), 96'(0));
      d_req = '0;
      clk_step(); #2;
      check("c3_no_resp", 96'({if_resp.valid, d_resp.valid}), 96'(0));
      check("c3_no_m_req", 96'(m_req.valid), 96'(0));
      clk_step(); #2;
      check("c4_m_req_if", 96'(m_req), 96'(mk(1'b0, 1'b0, 32'h20, 32'h0)));
      clk_step(); #2;
      check("c5_if_resp", 96'(if_resp), 96'({1'b1, 32'h5000_0020}));
      check("c5_d_resp_off", 96'(d_resp.valid), 96'(0));
      if_req = '0;

      // anti-starvation: ifetch wins after exactly 4 data grants
      d_req  = mk(1'b0, 1'b0, 32'h200, 32'h0);
      if_req = mk(1'b0, 1'b0, 32'h300, 32'h0);
      n_seen = 0;
      for (int c = 0; c < 40 && n_seen < 5; c++) begin
         clk_step(); #2;
         if (m_req.valid) begin
            gaddr[n_seen] = m_req.addr;
            n_seen++;
         end
      end
      check("starve_grant_count", 96'(n_seen), 96'(5));
      for (int i = 0; i < 4; i++) check("starve_data_grant", 96'(gaddr[i]), 96'(32'h200));
      check("starve_if_grant", 96'(gaddr[4]), 96'(32'h300));
      clk_step(); #2;
      check("starve_if_resp", 96'(if_resp), 96'({1'b1, 32'h5000_0300}));
      if_req = '0;
      for (int c = 0; c < 10; c++) begin
         clk_step(); #2;
         if (d_resp.valid) break;
      end
      d_req = '0;

      // LL 0x100 then SC 0x102 succeeds as a write
      run_d(mk(1'b0, 1'b1, 32'h100, 32'h0), rd, lat);
      check("ll_rdata", 96'(rd), 96'(32'h5000_0100));
      check("ll_fwd_read", 96'(last_acc), 96'(mk(1'b0, 1'b0, 32'h100, 32'h0)));
      acc0 = n_acc;
      run_d(mk(1'b1, 1'b1, 32'h102, 32'hAB), rd, lat);
      check("sc_pass_rdata", 96'(rd), 96'(0));
      check("sc_pass_write", 96'(last_acc), 96'(mk(1'b1, 1'b0, 32'h102, 32'hAB)));
      check("sc_pass_acc", 96'(n_acc - acc0), 96'(1));
      check("sc_pass_lat", 96'(lat), 96'(2));
      // reservation consumed by that SC
      acc0 = n_acc;
      run_d(mk(1'b1, 1'b1, 32'h100, 32'h55), rd, lat);
      check("sc_after_sc_rdata", 96'(rd), 96'(1));
      check("sc_after_sc_acc", 96'(n_acc - acc0), 96'(0));

      // LL, plain write to the same word, SC fails without a memory access
      run_d(mk(1'b0, 1'b1, 32'h100, 32'h0), rd, lat);
      run_d(mk(1'b1, 1'b0, 32'h100, 32'h11), rd, lat);
      acc0 = n_acc;
      run_d(mk(1'b1, 1'b1, 32'h100, 32'h22), rd, lat);
      check("sc_kill_rdata", 96'(rd), 96'(1));
      check("sc_kill_lat", 96'(lat), 96'(1));
      check("sc_kill_acc", 96'(n_acc - acc0), 96'(0));

      // write to the neighbouring word keeps the reservation; low bits ignored
      run_d(mk(1'b0, 1'b1, 32'h100, 32'h0), rd, lat);
      run_d(mk(1'b1, 1'b0, 32'h104, 32'h11), rd, lat);
      run_d(mk(1'b1, 1'b1, 32'h103, 32'h33), rd, lat);
      check("sc_neigh_rdata", 96'(rd), 96'(0));
      check("sc_neigh_write", 96'(last_acc), 96'(mk(1'b1, 1'b0, 32'h103, 32'h33)));

      // a second LL replaces the reservation
      run_d(mk(1'b0, 1'b1, 32'h100, 32'h0), rd, lat);
      run_d(mk(1'b0, 1'b1, 32'h200, 32'h0), rd, lat);
      acc0 = n_acc;
      run_d(mk(1'b1, 1'b1, 32'h100, 32'h44), rd, lat);
      check("sc_replaced_rdata", 96'(rd), 96'(1));
      check("sc_replaced_acc", 96'(n_acc - acc0), 96'(0));

      // back-pressure: m_ready low for 3 ISSUE cycles
      clk_step(); #2;
      m_ready = 1'b0;
      d_req   = mk(1'b0, 1'b0, 32'h40, 32'h0);
      if_req  = mk(1'b0, 1'b0, 32'h44, 32'h0);
      acc0    = n_acc;
      clk_step(); #2;
      for (int c = 0; c < 3; c++) begin
         check("stall_m_req", 96'(m_req), 96'(mk(1'b0, 1'b0, 32'h40, 32'h0)));
         check("stall_no_resp", 96'({if_resp.valid, d_resp.valid}), 96'(0));
         clk_step(); #2;
      end
      m_ready = 1'b1;
      check("stall_m_req_after", 96'(m_req), 96'(mk(1'b0, 1'b0, 32'h40, 32'h0)));
      check("stall_acc", 96'(n_acc - acc0), 96'(0));
      clk_step(); #2;
      check("stall_d_resp", 96'(d_resp), 96'({1'b1, 32'h5000_0040}));
      d_req = '0;
      rd = '0;
      for (int c = 0; c < 10; c++) begin
         clk_step(); #2;
         if (if_resp.valid) begin
            rd = if_resp.rdata;
            break;
         end
      end
      check("stall_if_resp", 96'(rd), 96'(32'h5000_0044));
      if_req = '0;

      // reset while WAITing, late memory response ignored, reservation lost
      run_d(mk(1'b0, 1'b1, 32'h100, 32'h0), rd, lat);
      clk_step(); #2;
      mem_auto = 1'b0;
      d_req    = mk(1'b0, 1'b0, 32'h80, 32'h0);
      clk_step(); #2;
      clk_step(); #2;
      check("wait_no_m_req", 96'(m_req.valid), 96'(0));
      check("wait_no_resp", 96'({if_resp.valid, d_resp.valid}), 96'(0));
      rst_n = 1'b0;
      #1;
      check("midrst_m_req", 96'(m_req), 96'(0));
      check("midrst_d_resp", 96'(d_resp), 96'(0));
      d_req = '0;
      clk_step(); #2;
      rst_n = 1'b1;
      clk_step();
      m_resp.valid = 1'b1;
      m_resp.rdata = 32'hDEAD_BEEF;
      #2;
      check("late_resp_d", 96'(d_resp), 96'(0));
      check("late_resp_if", 96'(if_resp), 96'(0));
      mem_auto = 1'b1;
      clk_step(); #2;
      acc0 = n_acc;
      run_d(mk(1'b1, 1'b1, 32'h100, 32'h66), rd, lat);
      check("rst_resv_sc_rdata", 96'(rd), 96'(1));
      check("rst_resv_sc_acc", 96'(n_acc - acc0), 96'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
